// File: rtl/tnn_pkg.sv
// Shared constants, types and defaults for the classifier front-end quantizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tnn_pkg;

    localparam int N_FEAT = 5;   // features per frame, fixed to classifier arity
    localparam int Q_W    = 2;   // quantized width per feature
    localparam int N_THR  = 3;   // thresholds per feature

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

    // Reset threshold i of a feature: (i+1)/4 of the full raw range.
    function automatic int dflt_thr(input int feat_w, input int i);
        return (i + 1) << (feat_w - 2);
    endfunction

endpackage

// File: rtl/tnn_feature_quantizer_if.sv
// Stream bundle: raw feature beats in, quantized vector out.
// Latency: n/a (wires only).
// Backpressure: s_ready/m_ready valid-ready handshakes on each side.
interface tnn_feature_quantizer_if #(
    parameter int FEAT_W = 8
);
    import tnn_pkg::*;

    logic                    s_valid;
    logic                    s_ready;
    logic [FEAT_W-1:0]       s_data;
    logic                    s_last;
    logic                    m_valid;
    logic                    m_ready;
    logic [Q_W*N_FEAT-1:0]   m_vec;

    // Quantizer side: consumes the sample stream, produces the vector.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_vec
    );

    // Environment side: produces samples, consumes vectors.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_vec
    );

endinterface

// File: rtl/tnn_thermo_quant.sv
// Thermometer quantizer: counts how many of three thresholds the sample meets.
// Latency: combinational.
// Backpressure: none.
module tnn_thermo_quant
    import tnn_pkg::*;
#(
    parameter int FEAT_W = 8
) (
    input  logic [FEAT_W-1:0]       x_i,
    input  logic [N_THR*FEAT_W-1:0] thr_i,   // {t2, t1, t0}
    output logic [Q_W-1:0]          q_o
);

    // Count of satisfied compares; threshold order is not assumed.
    always_comb begin
        q_o = '0;
        for (int i = 0; i < N_THR; i++) begin
            if (x_i >= thr_i[i*FEAT_W +: FEAT_W]) begin
                q_o = q_o + Q_W'(1);
            end
        end
    end

endmodule

// File: rtl/tnn_feature_quantizer.sv
// Frames raw feature beats, quantizes each to 2 bits and emits a 10-bit vector.
// Latency: vector valid the cycle after the final beat is accepted.
// Backpressure: stalls only the final beat while the output register is full and not popped.
module tnn_feature_quantizer
    import tnn_pkg::*;
#(
    parameter int FEAT_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_addr,
    input  logic [N_THR*FEAT_W-1:0]  cfg_data,
    tnn_feature_quantizer_if.slave   sif,
    output logic                     err_frame,
    output logic [ERR_W-1:0]         err_cnt
);

    localparam int                IDX_W    = 3;
    localparam int                VEC_W    = Q_W * N_FEAT;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FEAT - 1);

    logic [N_THR*FEAT_W-1:0] thr_q [N_FEAT];
    logic [N_THR*FEAT_W-1:0] thr_sel;
    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [VEC_W-1:0]        stage_q, stage_d;
    logic [VEC_W-1:0]        vec_q, vec_d;
    logic                    vld_q, vld_d;
    logic                    err_q, err_d;
    logic [ERR_W-1:0]        cnt_q, cnt_d;
    logic [Q_W-1:0]          q;
    logic                    acc;
    logic                    pop;
    logic                    at_last;

    // Threshold table: defaults on reset, whole-entry writes for valid addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_FEAT; k++) begin
                for (int i = 0; i < N_THR; i++) begin
                    thr_q[k][i*FEAT_W +: FEAT_W] <= FEAT_W'(dflt_thr(FEAT_W, i));
                end
            end
        end else if (cfg_we) begin
            for (int k = 0; k < N_FEAT; k++) begin
                if (cfg_addr == 3'(k)) begin
                    thr_q[k] <= cfg_data;
                end
            end
        end
    end

    // Select the threshold entry of the feature currently expected.
    always_comb begin
        thr_sel = thr_q[0];
        for (int k = 1; k < N_FEAT; k++) begin
            if (idx_q == IDX_W'(k)) begin
                thr_sel = thr_q[k];
            end
        end
    end

    tnn_thermo_quant #(
        .FEAT_W (FEAT_W)
    ) u_quant (
        .x_i   (sif.s_data),
        .thr_i (thr_sel),
        .q_o   (q)
    );

    // Only the final beat can be held off, and only by an unpopped full output.
    assign at_last     = (idx_q == LAST_IDX);
    assign pop         = vld_q && sif.m_ready;
    assign sif.s_ready = (state_q == DRAIN) || !at_last || !vld_q || sif.m_ready;
    assign acc         = sif.s_valid && sif.s_ready;

    // Framing state machine: staging, output load, error detection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        vec_d   = vec_q;
        vld_d   = pop ? 1'b0 : vld_q;
        err_d   = 1'b0;
        if (acc) begin
            if (state_q == DRAIN) begin
                if (sif.s_last) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end else begin
                stage_d[int'(idx_q)*Q_W +: Q_W] = q;
                if (!at_last) begin
                    if (sif.s_last) begin
                        idx_d = '0;          // short frame
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (sif.s_last) begin
                    vec_d = {q, stage_q[VEC_W-Q_W-1:0]};
                    vld_d = 1'b1;
                    idx_d = '0;
                end else begin
                    err_d   = 1'b1;          // long frame: drop the rest silently
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
        end
        cnt_d = cnt_q;
        if (err_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    // State registers; reset drops any partial frame and pending vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            stage_q <= '0;
            vec_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sif.m_valid = vld_q;
    assign sif.m_vec   = vec_q;
    assign err_frame   = err_q;
    assign err_cnt     = cnt_q;

endmodule

// File: doc/tnn_feature_quantizer.md
# tnn_feature_quantizer

Upstream front end of the evolved breast-cancer classifier core (five 2-bit feature inputs, one-bit decision). Accepts a stream of raw FEAT_W-bit feature samples, one feature per beat, framed by `s_last`. Quantizes each sample to 2 bits against per-feature programmable thresholds and assembles a 10-bit vector. Presents the vector through a single-entry valid/ready output register that feeds the combinational classifier directly.

## Interface
- `FEAT_W`, 8, raw feature sample width
- `N_FEAT`, 5, features per frame (fixed to classifier arity)
- `ERR_W`, 8, width of saturating frame-error counter
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, synchronous, active-high
- `cfg_we` in 1: threshold write strobe
- `cfg_addr` in 3: feature index 0..4; writes to 5..7 ignored
- `cfg_data` in 3*FEAT_W: {t2, t1, t0}
- `s_valid` in 1 / `s_ready` out 1: input handshake
- `s_data` in FEAT_W: raw feature sample
- `s_last` in 1: marks final feature of frame
- `m_valid` out 1 / `m_ready` in 1: output handshake
- `m_vec` out 2*N_FEAT: quantized vector; bits [2k+1:2k] = feature k (k=0 → classifier input a, … k=4 → input e)
- `err_frame` out 1: one-cycle pulse on a malformed frame
- `err_cnt` out ERR_W: saturating count of malformed frames

## Operation
- Quantization: q = number of thresholds t_i (i=0..2) with s_data >= t_i, unsigned compare; defined for any threshold order (non-monotonic thresholds are legal, not reordered).
- Threshold table: 5 entries × 3 × FEAT_W. Reset value per entry t0=64, t1=128, t2=192 (scaled to FEAT_W as 1/4, 1/2, 3/4 of 2^FEAT_W). Write takes effect from the cycle after `cfg_we`; a feature accepted in the same cycle as a write to its entry uses the old value.
- Feature index `idx` 0..N_FEAT-1. On each accepted beat (`s_valid && s_ready`) q is written into staging slot `idx`.
- States:
  - COLLECT: normal accumulation.
    - Beat with idx<N_FEAT-1 and `s_last`=0: idx++.
    - Beat with idx<N_FEAT-1 and `s_last`=1 (short frame): discard staging, idx←0, error.
    - Beat with idx=N_FEAT-1 and `s_last`=1: transfer staging (including this beat's q) to output register, m_valid←1, idx←0.
    - Beat with idx=N_FEAT-1 and `s_last`=0 (long frame): discard, error, go DRAIN.
  - DRAIN: accept and drop beats (`s_ready`=1) until a beat with `s_last`=1, then idx←0, go COLLECT. No second error for the same frame.
- `s_ready` = (state=DRAIN) or idx<N_FEAT-1 or !m_valid or m_ready. Combinational path from `m_ready`; a final beat and an output pop may occur in the same cycle.
- Output register: held stable while m_valid && !m_ready. Cleared on pop (m_valid←0) unless reloaded the same cycle.
- Error: `err_frame` pulses high the cycle after the offending beat; `err_cnt` increments, saturating at all-ones.

## Timing
- Reset: m_valid=0, m_vec=0, err_frame=0, err_cnt=0, idx=0, state=COLLECT, thresholds set to defaults. `s_ready` is 1 out of reset.
- Latency: final feature accepted at edge N → m_valid=1 and m_vec valid after edge N. Throughput one feature per cycle; back-to-back frames run without bubbles when `m_ready` is held high.
- Reset mid-frame: partial frame lost, no error counted.
- Reset with m_valid=1: the vector is dropped.

## Structure
- Shared package `tnn_pkg`: N_FEAT, Q_W=2, default-threshold function of FEAT_W, state enum {COLLECT, DRAIN}.
- One sub-module, `tnn_thermo_quant`: combinational three-compare-and-count quantizer. Instantiated once on the muxed threshold entry selected by idx.

## Test plan
- Defaults, frame {10,64,127,128,255} with s_last on beat 5 → m_vec = {3,2,1,1,0} (feature4..0) = 10'b11_10_01_01_00, m_valid one cycle after beat 5.
- Write addr 2 = {t2=30,t1=20,t0=200}, feed 25 as feature 2 → q=1. Write with same-cycle accept → old thresholds apply.
- Hold m_ready=0 with m_valid=1; send next frame → beats 0..3 accepted, s_ready=0 at idx=4 until m_ready=1; both frames delivered in order and unaltered.
- s_last on beat 3 → err_frame pulse, err_cnt=1, no m_valid. Next well-formed frame is output correctly.
- 7-beat frame with s_last on beat 7 → one error, beats 6–7 dropped, next frame correct. 260 errors → err_cnt=255.
- Assert rst after 3 beats → next 5-beat frame is output correctly; err_cnt stays 0.
